axis_dot_frame_tx: RTL and testbench
====================================

// Module: axis_dot_frame_tx
// PURPOSE
//  Source side of the dot-product matrix stream: holds a 4x4 matrix plus a
//  4-element vector in a local buffer and, on start, transmits them as one
//  AXI4-Stream frame (TLAST on the final beat) into the dot unit's input port.
//  Loaded by a simple word-write port from the control side; fully backpressure-aware.
// PARAMETERS
//  DATA_W  32  width of one stream beat / buffer word
//  N_ROWS   4  matrix rows
//  N_COLS   4  matrix columns = vector length
//  (FRAME_LEN = N_COLS + N_ROWS*N_COLS = 20 words; ADDR_W = clog2(FRAME_LEN) = 5)
// PORTS
//  aclk                clk   in   1       single clock, all logic rising-edge
//  aresetn             rst   in   1       synchronous, active-low reset
//  wr_en                     in   1       buffer write strobe
//  wr_addr                   in   ADDR_W  word index 0..FRAME_LEN-1
//  wr_data                   in   DATA_W  word to store
//  start                     in   1       launch one frame (pulse)
//  busy                      out  1       frame in progress
//  done                      out  1       1-cycle pulse after last beat accepted
//  OUTPUT_AXIS_TDATA         out  DATA_W  beat data
//  OUTPUT_AXIS_TLAST         out  1       high on beat FRAME_LEN-1 only
//  OUTPUT_AXIS_TVALID        out  1       beat valid
//  OUTPUT_AXIS_TREADY        in   1       sink ready
// BEHAVIOUR
//  - Reset (aresetn=0 at edge): buffer words=0, state IDLE, beat count=0,
//    busy=0, done=0, TVALID=0, TLAST=0, TDATA=0. Reset mid-frame aborts
//    immediately; no TLAST emitted; outputs at reset values next cycle.
//  - Buffer map: addr 0..N_COLS-1 = vector; addr N_COLS.. = matrix row-major
//    (row r, col c at N_COLS + r*N_COLS + c). Frame order = address order.
//  - Writes: accepted only in IDLE; wr_en while busy, or wr_addr>=FRAME_LEN, ignored.
//  - FSM IDLE -> SEND on start (IDLE only; start while busy ignored).
//    wr_en + start same cycle in IDLE: write commits, frame carries new word.
//  - Latency: start at edge t -> TVALID=1 with beat 0 after edge t, i.e.
//    busy=1 and TVALID=1 in same cycle; all outputs registered.
//  - Handshake: beat transfers when TVALID&&TREADY. TDATA/TLAST/TVALID held
//    stable while TVALID&&!TREADY. TVALID never drops mid-frame without transfer.
//    Back-to-back beats at full rate when TREADY held high (1 beat/cycle).
//  - Beat counter 0..FRAME_LEN-1; TLAST=(count==FRAME_LEN-1).
//  - SEND -> DONE on transfer of TLAST beat: next cycle TVALID=0, TLAST=0,
//    busy=0, done=1 for exactly one cycle; then IDLE. Count wraps to 0.
//  - start during DONE cycle ignored; earliest relaunch is cycle after done.
//  - Buffer contents persist across frames; re-start resends same data.
// STRUCTURE
//  - Shared package dot_pkg: DOT_DATA_W, DOT_N_ROWS, DOT_N_COLS, DOT_FRAME_LEN,
//    DOT_ADDR_W, state enum {TX_IDLE, TX_SEND, TX_DONE}.
//  - One sub-module: dot_frame_regs (FRAME_LEN x DATA_W register bank, sync
//    write, combinational read by beat index). FSM/counter/output regs in top.
// TESTING
//  1 Load vector 1..4, matrix 5..20, start, TREADY=1 -> 20 consecutive beats
//    TDATA=1..20, TLAST only on beat 20 (value 20), done 1 cycle later.
//  2 Same load, TREADY toggled 1/0 each cycle -> identical 20-beat sequence,
//    TDATA/TLAST stable on every stalled cycle, done after 20th accept.
//  3 Start, during frame wr_en addr 0 data 0xDEAD and second start -> both
//    ignored; frame unchanged; next frame beat 0 still 1.
//  4 IDLE: wr_en addr 3 data 0xBEEF with start same cycle -> beat 3 = 0xBEEF;
//    wr_addr=25 write -> no buffer change.
//  5 Reset asserted after beat 7 accepted -> next cycle TVALID=0, busy=0;
//    new frame after load+start emits all-zero data except reloaded words.
//  6 Two starts back-to-back (second in cycle after done) -> two 20-beat
//    frames, exactly two TLAST and two done pulses.

Source files
------------

// File: rtl/dot_pkg.sv
// Shared constants and state encoding for the dot-product frame source.
package dot_pkg;

   localparam int DOT_DATA_W    = 32;
   localparam int DOT_N_ROWS    = 4;
   localparam int DOT_N_COLS    = 4;
   localparam int DOT_FRAME_LEN = DOT_N_COLS + DOT_N_ROWS * DOT_N_COLS;
   localparam int DOT_ADDR_W    = $clog2(DOT_FRAME_LEN);

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_SEND = 2'd1,
      TX_DONE = 2'd2
   } tx_state_t;

endpackage : dot_pkg

// File: rtl/dot_frame_regs.sv
// Frame buffer: DEPTH words, synchronous write, combinational read by beat index.
// Out-of-range indices write nothing and read as zero.
module dot_frame_regs
   import dot_pkg::*;
#(
   parameter int DATA_W = DOT_DATA_W,
   parameter int DEPTH  = DOT_FRAME_LEN,
   parameter int ADDR_W = DOT_ADDR_W
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Word storage: cleared on reset, one word written per accepted strobe.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_en && (wr_addr <= LAST_IDX)) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Read port: index past the end of the frame returns zero.
   always_comb begin
      rd_data = {DATA_W{1'b0}};
      if (rd_idx <= LAST_IDX) begin
         rd_data = mem_r[rd_idx];
      end else begin
         rd_data = {DATA_W{1'b0}};
      end
   end

endmodule : dot_frame_regs

// File: rtl/axis_dot_frame_tx.sv
// AXI4-Stream frame source: sends the stored vector followed by the row-major
// matrix as one frame, TLAST on the final beat, with full backpressure support.
module axis_dot_frame_tx
   import dot_pkg::*;
#(
   parameter  int DATA_W    = DOT_DATA_W,
   parameter  int N_ROWS    = DOT_N_ROWS,
   parameter  int N_COLS    = DOT_N_COLS,
   localparam int FRAME_LEN = N_COLS + N_ROWS * N_COLS,
   localparam int ADDR_W    = $clog2(FRAME_LEN)
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] OUTPUT_AXIS_TDATA,
   output logic              OUTPUT_AXIS_TLAST,
   output logic              OUTPUT_AXIS_TVALID,
   input  logic              OUTPUT_AXIS_TREADY
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

   tx_state_t         state_r,  state_s;
   logic [ADDR_W-1:0] count_r,  count_s;
   logic [DATA_W-1:0] tdata_r,  tdata_s;
   logic              tvalid_r, tvalid_s;
   logic              tlast_r,  tlast_s;
   logic              busy_r,   busy_s;
   logic              done_r,   done_s;

   logic              wr_accept_s;
   logic [ADDR_W-1:0] rd_idx_s;
   logic [DATA_W-1:0] rd_data_s;
   logic [DATA_W-1:0] beat_data_s;

   // Writes land only while idle and inside the frame.
   assign wr_accept_s = wr_en && (state_r == TX_IDLE) && (wr_addr <= LAST_IDX);

   // Idle prefetches beat 0; while sending, prefetch the beat after the current one.
   assign rd_idx_s = (state_r == TX_IDLE) ? ZERO_IDX : (count_r + ONE_IDX);

   // A write committing on the launch edge must appear in the frame, so forward it.
   assign beat_data_s = (wr_accept_s && (wr_addr == rd_idx_s)) ? wr_data : rd_data_s;

   dot_frame_regs #(
      .DATA_W (DATA_W),
      .DEPTH  (FRAME_LEN),
      .ADDR_W (ADDR_W)
   ) u_regs (
      .aclk    (aclk),
      .aresetn (aresetn),
      .wr_en   (wr_accept_s),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_idx  (rd_idx_s),
      .rd_data (rd_data_s)
   );

   // State, beat counter and all output registers; reset aborts any frame.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_r  <= TX_IDLE;
         count_r  <= ZERO_IDX;
         tdata_r  <= {DATA_W{1'b0}};
         tvalid_r <= 1'b0;
         tlast_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         count_r  <= count_s;
         tdata_r  <= tdata_s;
         tvalid_r <= tvalid_s;
         tlast_r  <= tlast_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
      end
   end

   // Next-state and next-output logic; everything holds unless a transition occurs.
   always_comb begin
      state_s  = state_r;
      count_s  = count_r;
      tdata_s  = tdata_r;
      tvalid_s = tvalid_r;
      tlast_s  = tlast_r;
      busy_s   = busy_r;
      done_s   = 1'b0;
      case (state_r)
         TX_IDLE: begin
            if (start) begin
               state_s  = TX_SEND;
               count_s  = ZERO_IDX;
               tdata_s  = beat_data_s;
               tvalid_s = 1'b1;
               tlast_s  = (ZERO_IDX == LAST_IDX);
               busy_s   = 1'b1;
            end else begin
               state_s  = TX_IDLE;
            end
         end
         TX_SEND: begin
            if (tvalid_r && OUTPUT_AXIS_TREADY) begin
               if (tlast_r) begin
                  state_s  = TX_DONE;
                  count_s  = ZERO_IDX;
                  tdata_s  = {DATA_W{1'b0}};
                  tvalid_s = 1'b0;
                  tlast_s  = 1'b0;
                  busy_s   = 1'b0;
                  done_s   = 1'b1;
               end else begin
                  count_s  = count_r + ONE_IDX;
                  tdata_s  = beat_data_s;
                  tlast_s  = ((count_r + ONE_IDX) == LAST_IDX);
               end
            end else begin
               state_s  = TX_SEND;
            end
         end
         TX_DONE: begin
            state_s = TX_IDLE;
         end
         default: begin
            state_s  = TX_IDLE;
            count_s  = ZERO_IDX;
            tdata_s  = {DATA_W{1'b0}};
            tvalid_s = 1'b0;
            tlast_s  = 1'b0;
            busy_s   = 1'b0;
         end
      endcase
   end

   assign busy               = busy_r;
   assign done               = done_r;
   assign OUTPUT_AXIS_TDATA  = tdata_r;
   assign OUTPUT_AXIS_TLAST  = tlast_r;
   assign OUTPUT_AXIS_TVALID = tvalid_r;

endmodule : axis_dot_frame_tx

// File: tb/tb_axis_dot_frame_tx.sv
// Scoreboard bench for axis_dot_frame_tx: the driver pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_axis_dot_frame_tx;

   localparam int LEN = 20;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        start;
   logic        busy;
   logic        done;
   logic [31:0] tdata;
   logic        tlast;
   logic        tvalid;
   logic        tready;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   beat_t       sb_q[$];
   logic [31:0] model[LEN];

   int  n_checks = 0;
   int  n_pass   = 0;
   int  tready_mode = 0;        // 0: always ready, 1: toggle every cycle
   int  cyc = 0;
   int  acc_in_frame = 0;
   int  first_acc_cyc = 0;
   int  last_acc_cyc = 0;
   int  last_cnt = 0;
   int  done_cnt = 0;
   bit  done_exp = 1'b0;
   bit  stall_prev = 1'b0;
   logic [31:0] stall_data;
   logic        stall_last;

   axis_dot_frame_tx dut (
      .aclk               (aclk),
      .aresetn            (aresetn),
      .wr_en              (wr_en),
      .wr_addr            (wr_addr),
      .wr_data            (wr_data),
      .start              (start),
      .busy               (busy),
      .done               (done),
      .OUTPUT_AXIS_TDATA  (tdata),
      .OUTPUT_AXIS_TLAST  (tlast),
      .OUTPUT_AXIS_TVALID (tvalid),
      .OUTPUT_AXIS_TREADY (tready)
   );

   // Free-running clock.
   always #5 aclk = ~aclk;

   task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Sink ready pattern.
   initial begin
      tready = 1'b1;
      forever begin
         @(posedge aclk); #1;
         if (tready_mode == 1) tready = ~tready;
         else tready = 1'b1;
      end
   end

   // Monitor: pops expectations on every accepted beat; checks stalls and done.
   initial begin
      forever begin
         @(negedge aclk);
         cyc++;
         if (done_exp || done) begin
            check("done_pulse", done == done_exp, 32'(done), 32'(done_exp));
            if (done) done_cnt++;
         end
         done_exp = 1'b0;
         if (aresetn && stall_prev) begin
            check("stall_hold", tvalid && tdata == stall_data && tlast == stall_last,
                  tdata, stall_data);
         end
         stall_prev = 1'b0;
         if (aresetn && tvalid && !tready) begin
            stall_prev = 1'b1;
            stall_data = tdata;
            stall_last = tlast;
         end
         if (aresetn && tvalid && tready) begin
            if (acc_in_frame == 0) first_acc_cyc = cyc;
            acc_in_frame++;
            if (tlast) begin
               last_cnt++;
               last_acc_cyc = cyc;
               done_exp = 1'b1;
            end
            if (sb_q.size() == 0) begin
               check("unexpected_beat", 1'b0, tdata, 32'd0);
            end else begin
               beat_t e;
               e = sb_q.pop_front();
               check("beat_data", tdata == e.data, tdata, e.data);
               check("beat_last", tlast == e.last, 32'(tlast), 32'(e.last));
            end
         end
      end
   end

   task automatic write_word(input logic [4:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge aclk); #1;
      wr_en = 1'b0;
      if (a < 5'd20) model[a] = d;
   endtask

   task automatic push_frame();
      beat_t b;
      for (int i = 0; i < LEN; i++) begin
         b.data = model[i];
         b.last = (i == LEN - 1);
         sb_q.push_back(b);
      end
      acc_in_frame = 0;
   endtask

   // Launch a frame, optionally with a same-cycle write.
   task automatic launch(input bit with_wr, input logic [4:0] a, input logic [31:0] d);
      if (with_wr) begin
         wr_en = 1'b1; wr_addr = a; wr_data = d;
         if (a < 5'd20) model[a] = d;
      end
      push_frame();
      start = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
      wr_en = 1'b0;
      check("launch_busy_valid", busy && tvalid, {30'd0, busy, tvalid}, 32'd3);
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge aclk); #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_timeout", seen, 32'(seen), 32'd1);
      check("queue_drained", sb_q.size() == 0, 32'(sb_q.size()), 32'd0);
   endtask

   task automatic do_reset(input int cycles);
      aresetn = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge aclk); #1;
      end
      sb_q.delete();
      for (int i = 0; i < LEN; i++) model[i] = 32'd0;
      check("rst_tvalid", tvalid == 1'b0, 32'(tvalid), 32'd0);
      check("rst_busy",   busy == 1'b0,   32'(busy),   32'd0);
      check("rst_done",   done == 1'b0,   32'(done),   32'd0);
      check("rst_tlast",  tlast == 1'b0,  32'(tlast),  32'd0);
      check("rst_tdata",  tdata == 32'd0, tdata,       32'd0);
      aresetn = 1'b1;
   endtask

   initial begin
      int l0, d0;
      aresetn = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; start = 1'b0;
      @(posedge aclk); #1;
      do_reset(2);

      // 1: load 1..20, full-rate frame.
      for (int i = 0; i < LEN; i++) write_word(5'(i), 32'(i + 1));
      tready_mode = 0;
      launch(1'b0, 5'd0, 32'd0);
      wait_done();
      check("t1_consecutive", last_acc_cyc - first_acc_cyc == LEN - 1,
            32'(last_acc_cyc - first_acc_cyc), 32'(LEN - 1));

      // 2: toggling ready, same data.
      @(posedge aclk); #1;
      tready_mode = 1;
      launch(1'b0, 5'd0, 32'd0);
      wait_done();
      tready_mode = 0;

      // 3: write and start during a frame are ignored.
      @(posedge aclk); #1;
      launch(1'b0, 5'd0, 32'd0);
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000DEAD; start = 1'b1;
      @(posedge aclk); #1;
      wr_en = 1'b0; start = 1'b0;
      wait_done();
      @(posedge aclk); #1;
      launch(1'b0, 5'd0, 32'd0);
      wait_done();

      // 4: write with start in the same cycle; out-of-range write ignored.
      @(posedge aclk); #1;
      launch(1'b1, 5'd3, 32'h0000BEEF);
      wait_done();
      @(posedge aclk); #1;
      write_word(5'd25, 32'h12345678);
      launch(1'b0, 5'd0, 32'd0);
      wait_done();

      // 5: reset mid-frame, then partial reload.
      @(posedge aclk); #1;
      tready_mode = 1;
      launch(1'b0, 5'd0, 32'd0);
      for (int i = 0; i < 200; i++) begin
         if (acc_in_frame >= 7) break;
         @(posedge aclk); #1;
      end
      check("t5_reached_beat7", acc_in_frame >= 7, 32'(acc_in_frame), 32'd7);
      do_reset(1);
      tready_mode = 0;
      @(posedge aclk); #1;
      check("t5_idle_after_rst", !tvalid && !busy, {30'd0, tvalid, busy}, 32'd0);
      write_word(5'd5, 32'h00000055);
      write_word(5'd19, 32'h00000077);
      launch(1'b0, 5'd0, 32'd0);
      wait_done();

      // 6: back-to-back frames, second start in the cycle after done.
      @(posedge aclk); #1;
      l0 = last_cnt; d0 = done_cnt;
      launch(1'b0, 5'd0, 32'd0);
      wait_done();
      @(posedge aclk); #1;
      launch(1'b0, 5'd0, 32'd0);
      wait_done();
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      check("t6_tlast_count", last_cnt - l0 == 2, 32'(last_cnt - l0), 32'd2);
      check("t6_done_count",  done_cnt - d0 == 2, 32'(done_cnt - d0), 32'd2);
      check("end_idle", !tvalid && !busy && sb_q.size() == 0, {30'd0, tvalid, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_axis_dot_frame_tx
